// File: rtl/hazard_unit_mc_if.sv
// Hazard controller bundle: pipeline-side inputs and per-stage controls.
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D, Rs2D;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic              RegWriteE;
  logic [1:0]        ResultSrcE;
  logic              PCSrcE;
  logic              McStartE;
  logic [REG_AW-1:0] RdM;
  logic              RegWriteM;
  logic              MemReqM;
  logic              DReadyM;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteW;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushM, FlushW;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              McBusy;
  logic              McDoneE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE,
    output RegWriteE, ResultSrcE, PCSrcE, McStartE,
    output RdM, RegWriteM, MemReqM, DReadyM,
    output RdW, RegWriteW,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushM, FlushW,
    input  ForwardAE, ForwardBE, McBusy, McDoneE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE,
    input  RegWriteE, ResultSrcE, PCSrcE, McStartE,
    input  RdM, RegWriteM, MemReqM, DReadyM,
    input  RdW, RegWriteW,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushM, FlushW,
    output ForwardAE, ForwardBE, McBusy, McDoneE
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard controller with multi-cycle E hold and data-memory freeze.
// Define HAZ_FWD_EN for forwarding; otherwise RAW hazards stall.
module hazard_unit_mc #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 34
) (
  input logic              clk,
  input logic              rst_n,
  hazard_unit_mc_if.slave  hz
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int CW = $clog2(MC_LAT);
  localparam logic [CW-1:0] C_LOAD = CW'(MC_LAT - 2);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [REG_AW-1:0] X0 = '0;

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  logic w_memstall;
  logic w_mchold;
  logic w_lw;
  logic w_raw;
  logic w_dstall;
  logic w_br;

  assign w_memstall = hz.MemReqM & ~hz.DReadyM;
  assign w_mchold = hz.McStartE & (r_state != S_DONE);

  // The count keeps running under memstall; only the DONE exit waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (hz.McStartE) begin
            r_state <= S_RUN;
            r_cnt <= C_LOAD;
          end
        end
        S_RUN: begin
          if (r_cnt == C_ONE) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_DONE: begin
          if (!w_memstall) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_lw = hz.ResultSrcE[0] & hz.RegWriteE
              & (hz.RdE != X0)
              & ((hz.Rs1D == hz.RdE) | (hz.Rs2D == hz.RdE));

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdm,
    input logic              wem,
    input logic [REG_AW-1:0] rdw,
    input logic              wew
  );
    logic [1:0] sel;
    sel = 2'b00;
    unique case (1'b1)
      (rs != X0) & wem & (rs == rdm): sel = 2'b10;
      (rs != X0) & wew & (rs == rdw): sel = 2'b01;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

  function automatic logic raw_hit(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rde,
    input logic              wee,
    input logic [REG_AW-1:0] rdm,
    input logic              wem
  );
    return (rs != X0)
         & ((wee & (rs == rde)) | (wem & (rs == rdm)));
  endfunction

  logic w_unused;

`ifdef HAZ_FWD_EN
  assign w_raw = 1'b0;
  assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM,
                                hz.RdW, hz.RegWriteW);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM,
                                hz.RdW, hz.RegWriteW);
  assign w_unused = ^{hz.ResultSrcE[1]};
`else
  // Write-through regfile: W never needs a stall.
  assign w_raw = raw_hit(hz.Rs1D, hz.RdE, hz.RegWriteE,
                         hz.RdM, hz.RegWriteM)
               | raw_hit(hz.Rs2D, hz.RdE, hz.RegWriteE,
                         hz.RdM, hz.RegWriteM);
  assign hz.ForwardAE = 2'b00;
  assign hz.ForwardBE = 2'b00;
  assign w_unused = ^{hz.ResultSrcE[1], hz.RdW, hz.RegWriteW,
                      hz.Rs1E, hz.Rs2E,
                      fwd_sel(X0, X0, 1'b0, X0, 1'b0)};
`endif

  assign w_dstall = (w_lw | w_raw) & ~w_memstall & ~w_mchold;
  assign w_br = hz.PCSrcE & ~w_memstall;

  assign hz.StallF = w_memstall | w_mchold | w_dstall;
  assign hz.StallD = w_memstall | w_mchold | w_dstall;
  assign hz.StallE = w_memstall | w_mchold;
  assign hz.StallM = w_memstall;
  assign hz.FlushD = w_br;
  assign hz.FlushE = w_br | w_dstall;
  assign hz.FlushM = w_mchold & ~w_memstall;
  assign hz.FlushW = w_memstall;
  assign hz.McBusy = w_mchold;
  assign hz.McDoneE = (r_state == S_DONE);

endmodule
